pipe_if_stage: RTL
==================

Name: pipe_if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipelined MIPS CPU. Sits directly upstream of the ID-stage control/decode logic.
- Holds the PC and selects the next PC from the ID-stage pcsource (delayed-branch semantics). Fetches over a variable-latency req/ack instruction-memory port.
- Presents inst/dpc4 to ID, honouring ID's nostall hold. Uses a one-entry skid buffer and a pending-redirect register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clock  input  1  rising-edge clock
resetn  input  1  asynchronous reset, active-low
pcsource  input  2  from ID: 00 pc+4, 01 bpc (beq/bne taken), 10 rpc (jr), 11 jpc (j/jal)
bpc  input  32  branch target from ID
rpc  input  32  jr target (forwarded rs) from ID
jpc  input  32  jump target from ID
nostall  input  1  from ID: 1 = ID instruction advances this cycle, 0 = hold IF/ID
imem_req  output  1  fetch request, address valid
imem_addr  output  32  fetch address (= pc)
imem_ack  input  1  rdata valid for current request; single-cycle pulse
imem_rdata  input  32  fetched instruction
pc  output  32  current fetch PC
dpc4  output  32  IF/ID register: PC+4 of instruction in ID
inst  output  32  IF/ID register: instruction in ID (32'h0 = nop bubble)
dvalid  output  1  IF/ID register: inst is a real fetched instruction

Behaviour:
- Reset (async, resetn=0):
  - pc=RESET_PC, dpc4=0, inst=0, dvalid=0, state=REQ, redir_pending=0, ibuf=0.
  - imem_req forced 0 while resetn=0.
- FSM states: REQ (request outstanding), BUF (fetched inst parked in ibuf, ID stalled).
- Outputs by state:
  - imem_req = (state==REQ) & resetn; imem_addr = pc, combinational.
  - At most one outstanding request; imem_addr stable until ack.
- redirect = dvalid & nostall & (pcsource != 00). Target mux: 01 bpc, 10 rpc, 11 jpc.
- npc priority:
  1. redir_pending: redir_pc.
  2. redirect: target.
  3. otherwise pc+4 (32-bit wrap, 0xFFFF_FFFC+4 = 0).
- REQ, imem_ack=1, nostall=1:
  - IF/ID <= {pc+4, imem_rdata, 1}; pc <= npc; redir_pending <= 0; stay REQ.
- REQ, imem_ack=1, nostall=0:
  - ibuf <= imem_rdata; IF/ID held; pc held; go BUF.
- REQ, imem_ack=0, nostall=1:
  - IF/ID <= {dpc4, 32'h0, 0} (bubble); pc held.
  - If redirect: redir_pc <= target, redir_pending <= 1. The in-flight fetch is the delay slot; redirect applies after it completes.
- REQ, imem_ack=0, nostall=0: everything held.
- BUF, nostall=0: hold all; imem_req=0.
- BUF, nostall=1:
  - IF/ID <= {pc+4, ibuf, 1}; pc <= npc; redir_pending <= 0; go REQ.
  - Request for new pc is issued the next cycle (one-cycle request gap).
- Delayed branch: the instruction at branch PC+4 always enters ID; no flush or squash.
- A redirect in the same cycle the delay slot completes (ack or BUF release) goes straight to pc; no pending.
- Branch/jump in a delay slot is unsupported: a second redirect overwrites redir_pc.
- Reset mid-request abandons the fetch. Instruction memory shares resetn and must not ack after reset.
- imem_ack while state=BUF or imem_req=0 is illegal: ignored, and flagged by bench assertion.
- Latency: zero-wait memory with nostall=1 gives 1 instruction/cycle. inst appears in ID the cycle after ack.

Test Plan:
- Reset, ack every cycle, nostall=1 -> imem_addr 0,4,8,C on consecutive cycles. Cycle after each ack: inst=rdata, dpc4=4,8,C,10, dvalid=1.
- Ack at pc=8 with nostall=0 -> BUF, imem_req=0, inst/dpc4 held. Next cycle nostall=1 -> inst=ibuf, dpc4=0xC. imem_req=1 with addr 0xC the following cycle.
- 2 wait cycles per fetch, nostall=1 -> inst=0, dvalid=0 between real instructions. pc held until ack.
- beq in ID (pcsource=01, bpc=0x100) while fetch of 0x14 acks same cycle -> next imem_addr=0x100. Delay slot (0x14) in ID with dpc4=0x18.
- jr in ID (pcsource=10, rpc=0x2000), delay-slot fetch acks 3 cycles later -> redir_pending=1. After ack: delay slot in ID, next imem_addr=0x2000, redir_pending=0.
- resetn pulsed low mid-wait at pc=0x40 -> imem_req=0 immediately, inst=0, dvalid=0. After release: imem_addr=RESET_PC.

Source files
------------

// File: rtl/pipe_if_stage.sv
// pipe_if_stage: instruction-fetch stage plus IF/ID pipeline register.
//
// Holds the fetch PC and selects the next PC from the ID-stage pcsource.
// Branches are delayed: the instruction after the branch always reaches ID.
// Fetches go over a variable-latency req/ack memory port, with at most one
// request outstanding. A one-entry skid buffer (ibuf) parks a fetched word
// while ID is stalled. A pending-redirect register holds a branch target
// until the delay-slot fetch completes.
//
// Ports
//   clock, resetn            rising-edge clock, async active-low reset
//   pcsource                 00 pc+4, 01 bpc, 10 rpc, 11 jpc (from ID)
//   bpc, rpc, jpc            redirect targets from ID
//   nostall                  1 = ID instruction advances this cycle
//   imem_req, imem_addr      fetch request / address (address = pc)
//   imem_ack, imem_rdata     single-cycle ack with the fetched word
//   pc                       current fetch PC
//   dpc4, inst, dvalid       IF/ID register contents
//
// state | meaning
// ------+---------------------------------------------------------------
// REQ   | fetch request for pc outstanding
// BUF   | fetched word parked in ibuf, waiting for ID to accept it
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        nostall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);

  typedef enum logic {
    S_REQ = 1'b0,
    S_BUF = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt, dpc4_nxt, inst_nxt;
  logic        dvalid_nxt;
  logic [31:0] ibuf, ibuf_nxt;
  logic [31:0] redir_pc, redir_pc_nxt;
  logic        redir_pending, redir_pending_nxt;
  logic [31:0] target, npc, pc_plus4;
  logic        redirect;

  assign pc_plus4 = pc + 32'd4;

  // A redirect only counts when the branch/jump in ID is real and advancing.
  assign redirect = dvalid & nostall & (pcsource != 2'b00);

  always_comb begin
    target = jpc;
    case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = rpc;
      default: target = jpc;
    endcase
  end

  // A parked redirect wins: the word being completed now is its delay slot.
  assign npc = redir_pending ? redir_pc : (redirect ? target : pc_plus4);

  always_comb begin
    state_nxt         = state;
    pc_nxt            = pc;
    dpc4_nxt          = dpc4;
    inst_nxt          = inst;
    dvalid_nxt        = dvalid;
    ibuf_nxt          = ibuf;
    redir_pc_nxt      = redir_pc;
    redir_pending_nxt = redir_pending;
    case (state)
      S_REQ: begin
        if (imem_ack) begin
          if (nostall) begin
            dpc4_nxt          = pc_plus4;
            inst_nxt          = imem_rdata;
            dvalid_nxt        = 1'b1;
            pc_nxt            = npc;
            redir_pending_nxt = 1'b0;
          end else begin
            ibuf_nxt  = imem_rdata;
            state_nxt = S_BUF;
          end
        end else if (nostall) begin
          // Nothing to hand over: send a bubble, keep dpc4 as is.
          inst_nxt   = 32'h0;
          dvalid_nxt = 1'b0;
          if (redirect) begin
            redir_pc_nxt      = target;
            redir_pending_nxt = 1'b1;
          end
        end
      end
      S_BUF: begin
        if (nostall) begin
          dpc4_nxt          = pc_plus4;
          inst_nxt          = ibuf;
          dvalid_nxt        = 1'b1;
          pc_nxt            = npc;
          redir_pending_nxt = 1'b0;
          state_nxt         = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= S_REQ;
      pc            <= RESET_PC;
      dpc4          <= 32'h0;
      inst          <= 32'h0;
      dvalid        <= 1'b0;
      ibuf          <= 32'h0;
      redir_pc      <= 32'h0;
      redir_pending <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      dpc4          <= dpc4_nxt;
      inst          <= inst_nxt;
      dvalid        <= dvalid_nxt;
      ibuf          <= ibuf_nxt;
      redir_pc      <= redir_pc_nxt;
      redir_pending <= redir_pending_nxt;
    end
  end

  // Request drops combinationally with reset so an abandoned fetch is visible at once.
  assign imem_req  = resetn & (state == S_REQ);
  assign imem_addr = pc;

endmodule
